matmul_mac_pipe: RTL and testbench
==================================

Name: matmul_mac_pipe

Overview:
- Pipelined, parametrised multiply-accumulate unit for the MatrixMultiplication kernel datapath. It is the successor to the single-cycle combinational signed×unsigned multiplier.
- Accepts a stream of (a, b) operand beats with first/last group markers. Multiplies each pair with a configurable operand sign mode and accumulates the products across a group.
- Emits one dot-product result per group over a valid/ready handshake with full backpressure.
- Sits between the operand tile buffers and the result write-back stage.

Parameters:
- DIN0_WIDTH, 55, width of operand a (always signed two's complement).
- DIN1_WIDTH, 24, width of operand b.
- DIN1_SIGNED, 0, 0 = b zero-extended (unsigned), 1 = b signed.
- NUM_STAGE, 3, multiplier pipeline registers (>=1).
- ACC_WIDTH, 64, accumulator width (>= DIN0_WIDTH+DIN1_WIDTH+1 recommended).
- DOUT_WIDTH, 55, result width, taken from the low bits of the accumulator.
- CNT_WIDTH, 16, width of the beat counter.

Ports:
- ap_clk  in  1  clock, all logic rising-edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit can accept a beat.
- in_a  in  DIN0_WIDTH  operand a.
- in_b  in  DIN1_WIDTH  operand b.
- in_first  in  1  beat starts a new group.
- in_last  in  1  beat ends the group.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DOUT_WIDTH  group sum, low DOUT_WIDTH bits.
- out_count  out  CNT_WIDTH  number of beats in the group (wraps).
- out_ovf  out  1  sticky flag: the accumulator overflowed ACC_WIDTH during this group.

Behaviour:
- Reset (ap_rst_n low, asynchronous):
  - Clears all pipeline valid bits, the accumulator, the counter and the overflow flag.
  - out_valid=0, out_data=0, out_count=0, out_ovf=0.
  - in_ready=1 from the first clock after reset deasserts.
- Beat transfer: a beat transfers when in_valid && in_ready. Result transfer: out_valid && out_ready.
- Stall: stall = out_valid && !out_ready; in_ready = !stall.
  - While stalled, every pipeline stage, the accumulator and the output registers hold their values.
  - This is a single global enable; there are no bubbles-collapse requirements.
- Product: p = signed(a) × (DIN1_SIGNED ? signed(b) : {1'b0,b}), computed full-width (DIN0_WIDTH+DIN1_WIDTH bits), then sign-extended to ACC_WIDTH.
- Pipeline:
  - The product is available NUM_STAGE cycles after transfer, with first/last/valid carried alongside.
  - The accumulate stage adds 1 cycle.
  - Latency from the last beat's transfer to out_valid is NUM_STAGE+1 cycles, absent stalls.
- Accumulate stage, per valid beat:
  - first=1: acc = p, cnt = 1, ovf = 0.
  - first=0: acc = acc + p (wraps modulo 2^ACC_WIDTH), cnt = cnt+1 (wraps), ovf |= signed overflow of the add.
  - A first=0 beat after reset or after a completed group accumulates onto the current acc (0 after reset, or the previous sum). This is defined behaviour, not an error.
- Output:
  - On a beat with last=1, register out_data = new acc[DOUT_WIDTH-1:0], out_count = new cnt, out_ovf = new ovf, and set out_valid=1.
  - out_valid clears on the result transfer unless a new last beat loads in the same cycle, in which case it stays 1 with the new data.
- first=last=1 on the same beat: a single-term group, result = p, count = 1.
- Back-to-back single-beat groups: sustain 1 result per cycle when out_ready=1.
- out_data, out_count and out_ovf are stable while out_valid && !out_ready.
- Reset mid-group or mid-stall: all in-flight beats and any pending result are discarded.

Decomposition:
- Shared package matmul_pkg holds:
  - Default width constants (DIN0_W=55, DIN1_W=24, ACC_W=64).
  - Sign-mode localparams MODE_UNSIGNED=0 and MODE_SIGNED=1.
  - A typedef for the beat sideband struct {first, last}.
- Sub-module matmul_mul_pipe: NUM_STAGE-deep signed multiplier with an enable input and a valid/sideband shift chain. The accumulate stage and handshake logic live in the top.

Test Plan:
- Single-term group, a=-3, b=5, DIN1_SIGNED=0, first=last=1 → out_data=-15 (two's complement, 55 bits), out_count=1, out_valid exactly NUM_STAGE+1 cycles after transfer.
- Four-beat group, a={1,2,3,4}, b={10,10,10,10} → one result, out_data=100, out_count=4; no out_valid on beats 1–3.
- Unsigned b: a=1, b=24'hFFFFFF with DIN1_SIGNED=0 → 16777215. Same beat with DIN1_SIGNED=1 → -1.
- Backpressure: hold out_ready=0 for 5 cycles while results are pending → in_ready=0, out_data stable. Release → the next group's result follows with no beat lost or duplicated.
- Overflow: with ACC_WIDTH=64, add two products each near +2^62 → out_ovf=1, out_data equals the wrapped sum. The next first beat clears ovf.
- Assert ap_rst_n low mid-group and during a stall → out_valid=0 immediately. A new group after reset returns only the new group's sum.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and default widths for the MatrixMultiplication MAC datapath.
// Imported by the multiplier pipe and the MAC top.
package matmul_pkg;

    localparam int DIN0_W = 55;
    localparam int DIN1_W = 24;
    localparam int ACC_W  = 64;

    localparam int MODE_UNSIGNED = 0;
    localparam int MODE_SIGNED   = 1;

    // Group markers that travel alongside each operand beat
    typedef struct packed {
        logic first;
        logic last;
    } beat_side_t;

endpackage

// File: rtl/matmul_mul_pipe.sv
// NUM_STAGE-deep signed multiplier: a is signed, b is signed or zero-extended.
// A single enable freezes the whole chain; valid and sideband ride alongside the product.
module matmul_mul_pipe
    import matmul_pkg::*;
#(
    parameter int DIN0_WIDTH  = DIN0_W,
    parameter int DIN1_WIDTH  = DIN1_W,
    parameter int DIN1_SIGNED = MODE_UNSIGNED,
    parameter int NUM_STAGE   = 3
) (
    input  logic                             ap_clk,
    input  logic                             ap_rst_n,
    input  logic                             en,
    input  logic                             in_valid,
    input  beat_side_t                       in_side,
    input  logic [DIN0_WIDTH-1:0]            in_a,
    input  logic [DIN1_WIDTH-1:0]            in_b,
    output logic                             out_valid,
    output beat_side_t                       out_side,
    output logic [DIN0_WIDTH+DIN1_WIDTH-1:0] out_p
);

    localparam int PW = DIN0_WIDTH + DIN1_WIDTH;

    logic          b_msb;
    logic [PW-1:0] a_ext;
    logic [PW-1:0] b_ext;
    logic [PW-1:0] prod;

    // Both operands extended to the full product width, so a modular PW-bit
    // multiply yields the exact signed product.
    always_comb begin
        b_msb = (DIN1_SIGNED == MODE_SIGNED) ? in_b[DIN1_WIDTH-1] : 1'b0;
        a_ext = {{DIN1_WIDTH{in_a[DIN0_WIDTH-1]}}, in_a};
        b_ext = {{DIN0_WIDTH{b_msb}}, in_b};
        prod  = a_ext * b_ext;
    end

    logic [NUM_STAGE-1:0] vld_q;
    beat_side_t           side_q [NUM_STAGE];
    logic [PW-1:0]        prod_q [NUM_STAGE];

    // NOTE: sequential state is assigned with <= so every stage samples the
    // previous stage's pre-edge value; blocking here would collapse the chain.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            vld_q <= '0;
        end else if (en) begin
            vld_q[0] <= in_valid;
            for (int i = 1; i < NUM_STAGE; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // NOTE: the data/sideband arrays carry no reset; the valid bits alone
    // qualify them, which keeps the wide registers free of reset routing.
    always_ff @(posedge ap_clk) begin
        if (en) begin
            side_q[0] <= in_side;
            prod_q[0] <= prod;
            for (int i = 1; i < NUM_STAGE; i++) begin
                side_q[i] <= side_q[i-1];
                prod_q[i] <= prod_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[NUM_STAGE-1];
    assign out_side  = side_q[NUM_STAGE-1];
    assign out_p     = prod_q[NUM_STAGE-1];

endmodule

// File: rtl/matmul_mac_pipe.sv
// Pipelined multiply-accumulate: one dot-product result per first..last group,
// delivered over valid/ready with full backpressure via a global stall.
module matmul_mac_pipe
    import matmul_pkg::*;
#(
    parameter int DIN0_WIDTH  = DIN0_W,
    parameter int DIN1_WIDTH  = DIN1_W,
    parameter int DIN1_SIGNED = MODE_UNSIGNED,
    parameter int NUM_STAGE   = 3,
    parameter int ACC_WIDTH   = ACC_W,
    parameter int DOUT_WIDTH  = 55,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIN0_WIDTH-1:0] in_a,
    input  logic [DIN1_WIDTH-1:0] in_b,
    input  logic                  in_first,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DOUT_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  out_count,
    output logic                  out_ovf
);

    localparam int PW = DIN0_WIDTH + DIN1_WIDTH;

    logic en;
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;

    beat_side_t    in_side;
    logic          p_valid;
    beat_side_t    p_side;
    logic [PW-1:0] p_raw;

    assign in_side = '{first: in_first, last: in_last};

    matmul_mul_pipe #(
        .DIN0_WIDTH (DIN0_WIDTH),
        .DIN1_WIDTH (DIN1_WIDTH),
        .DIN1_SIGNED(DIN1_SIGNED),
        .NUM_STAGE  (NUM_STAGE)
    ) u_mul (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .en       (en),
        .in_valid (in_valid),
        .in_side  (in_side),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_valid(p_valid),
        .out_side (p_side),
        .out_p    (p_raw)
    );

    logic [ACC_WIDTH-1:0] p_ext;
    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] acc_sum;
    logic [ACC_WIDTH-1:0] acc_nxt;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic                 ovf_q;
    logic                 ovf_nxt;
    logic                 add_ovf;

    // Sign-extends (or wraps, when the accumulator is narrower) the product.
    assign p_ext   = ACC_WIDTH'(signed'(p_raw));
    assign acc_sum = acc_q + p_ext;
    assign add_ovf = (acc_q[ACC_WIDTH-1] == p_ext[ACC_WIDTH-1]) &&
                     (acc_sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);

    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        acc_nxt = acc_sum;
        cnt_nxt = cnt_q + CNT_WIDTH'(1);
        ovf_nxt = ovf_q | add_ovf;
        if (p_side.first) begin
            acc_nxt = p_ext;
            cnt_nxt = CNT_WIDTH'(1);
            ovf_nxt = 1'b0;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (en && p_valid) begin
            acc_q <= acc_nxt;
            cnt_q <= cnt_nxt;
            ovf_q <= ovf_nxt;
        end
    end

    // When not stalled the previous result is either absent or taken this
    // cycle, so out_valid simply follows whether a last beat is landing.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else if (en) begin
            out_valid <= p_valid && p_side.last;
            if (p_valid && p_side.last) begin
                out_data  <= acc_nxt[DOUT_WIDTH-1:0];
                out_count <= cnt_nxt;
                out_ovf   <= ovf_nxt;
            end
        end
    end

endmodule

// File: tb/tb_matmul_mac_pipe.sv
// Directed bench for matmul_mac_pipe: a vector table scored by a result monitor,
// plus hand-written latency, sign-mode, backpressure and reset sequences.
module tb_matmul_mac_pipe;

    localparam int NS = 3;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [54:0] in_a;
    logic [23:0] in_b;
    logic        in_first;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [54:0] out_data;
    logic [15:0] out_count;
    logic        out_ovf;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [54:0] s_out_data;
    logic [15:0] s_out_count;
    logic        s_out_ovf;

    always #5 ap_clk = ~ap_clk;

    matmul_mac_pipe #(.DIN1_SIGNED(0), .NUM_STAGE(NS)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_count(out_count), .out_ovf(out_ovf)
    );

    matmul_mac_pipe #(.DIN1_SIGNED(1), .NUM_STAGE(NS)) dut_s (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_data(s_out_data), .out_count(s_out_count), .out_ovf(s_out_ovf)
    );

    typedef struct {
        logic [54:0] data;
        logic [15:0] count;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [54:0] a;
        logic [23:0] b;
        logic        first;
        logic        last;
        logic [54:0] exp_data;
        logic [15:0] exp_count;
        logic        exp_ovf;
    } vec_t;

    res_t exp_q[$];
    res_t mon_e;
    vec_t tbl[12];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every accepted result is scored against the oldest expected result.
    always @(negedge ap_clk) begin
        if (ap_rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_result: got data %0h count %0d, expected none", out_data, out_count);
            end else begin
                mon_e = exp_q.pop_front();
                check("result_data", out_data, mon_e.data);
                check("result_count", out_count, mon_e.count);
                check("result_ovf", out_ovf, mon_e.ovf);
            end
        end
    end

    task automatic present(input logic [54:0] a, input logic [23:0] b, input logic f, input logic l);
        in_a = a; in_b = b; in_first = f; in_last = l; in_valid = 1'b1;
    endtask

    task automatic complete();
        int t = 0;
        @(negedge ap_clk);
        while (!in_ready && t < 200) begin
            @(negedge ap_clk);
            t++;
        end
        if (!in_ready) check("in_ready_timeout", in_ready, 1);
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [54:0] a, input logic [23:0] b, input logic f, input logic l);
        present(a, b, f, l);
        complete();
    endtask

    task automatic wait_out();
        int t = 0;
        @(negedge ap_clk);
        while (!out_valid && t < 50) begin
            @(negedge ap_clk);
            t++;
        end
        if (!out_valid) check("out_valid_timeout", out_valid, 1);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge ap_clk);
            #1;
            t++;
        end
        check("drain_pending", exp_q.size(), 0);
        repeat (2) @(posedge ap_clk);
        #1;
    endtask

    task automatic push(input logic [54:0] d, input logic [15:0] c, input logic o);
        exp_q.push_back('{d, c, o});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{55'd1, 24'd10, 1'b1, 1'b0, 55'd0, 16'd0, 1'b0};
        tbl[1]  = '{55'd2, 24'd10, 1'b0, 1'b0, 55'd0, 16'd0, 1'b0};
        tbl[2]  = '{55'd3, 24'd10, 1'b0, 1'b0, 55'd0, 16'd0, 1'b0};
        tbl[3]  = '{55'd4, 24'd10, 1'b0, 1'b1, 55'd100, 16'd4, 1'b0};
        tbl[4]  = '{55'd2, 24'd3, 1'b0, 1'b1, 55'd106, 16'd5, 1'b0};
        tbl[5]  = '{55'd5, 24'd6, 1'b1, 1'b1, 55'd30, 16'd1, 1'b0};
        tbl[6]  = '{55'(-2), 24'd7, 1'b1, 1'b1, 55'(-14), 16'd1, 1'b0};
        tbl[7]  = '{55'd0, 24'd9, 1'b1, 1'b1, 55'd0, 16'd1, 1'b0};
        tbl[8]  = '{55'(-7), 24'hFFFFFF, 1'b1, 1'b1, 55'(-117440505), 16'd1, 1'b0};
        tbl[9]  = '{55'h3F_FFFF_FFFF_FFFF, 24'd257, 1'b1, 1'b0, 55'd0, 16'd0, 1'b0};
        tbl[10] = '{55'h3F_FFFF_FFFF_FFFF, 24'd257, 1'b0, 1'b1, 55'h7F_FFFF_FFFF_FDFE, 16'd2, 1'b1};
        tbl[11] = '{55'd1, 24'd1, 1'b1, 1'b1, 55'd1, 16'd1, 1'b0};

        ap_rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_count", out_count, 0);
        check("rst_out_ovf", out_ovf, 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        check("rst_in_ready", in_ready, 1);

        // Table: multi-beat group, continuation after a group, back-to-back singles, overflow
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].last) push(tbl[i].exp_data, tbl[i].exp_count, tbl[i].exp_ovf);
            send(tbl[i].a, tbl[i].b, tbl[i].first, tbl[i].last);
        end
        drain();

        // Single-term group latency: out_valid rises exactly NS+1 edges after transfer
        push(55'(-15), 16'd1, 1'b0);
        present(55'(-3), 24'd5, 1'b1, 1'b1);
        for (int i = 1; i <= NS + 1; i++) begin
            @(posedge ap_clk);
            #1;
            if (i == 1) in_valid = 1'b0;
            check($sformatf("latency_cycle%0d", i), out_valid, (i == NS + 1));
        end
        drain();

        // Same beat through both sign modes
        push(55'd16777215, 16'd1, 1'b0);
        send(55'd1, 24'hFFFFFF, 1'b1, 1'b1);
        wait_out();
        check("signed_b_valid", s_out_valid, 1);
        check("signed_b_data", s_out_data, 55'h7F_FFFF_FFFF_FFFF);
        check("signed_b_count", s_out_count, 1);
        check("signed_b_in_ready", s_in_ready, 1);
        @(posedge ap_clk);
        #1;
        drain();

        // Backpressure: results held and input blocked, nothing lost or duplicated
        out_ready = 1'b0;
        push(55'd12, 16'd1, 1'b0);
        push(55'd25, 16'd1, 1'b0);
        push(55'(-6), 16'd1, 1'b0);
        send(55'd3, 24'd4, 1'b1, 1'b1);
        send(55'd5, 24'd5, 1'b1, 1'b1);
        wait_out();
        @(posedge ap_clk);
        #1;
        present(55'(-2), 24'd3, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge ap_clk);
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            check("stall_out_data", out_data, 55'd12);
        end
        @(posedge ap_clk);
        #1;
        out_ready = 1'b1;
        complete();
        drain();

        // Reset mid-group: partial sum and in-flight beats are discarded
        send(55'd9, 24'd9, 1'b1, 1'b0);
        send(55'd4, 24'd4, 1'b0, 1'b0);
        send(55'd3, 24'd3, 1'b0, 1'b0);
        send(55'd1, 24'd1, 1'b0, 1'b0);
        ap_rst_n = 1'b0;
        #1;
        check("midgroup_rst_out_valid", out_valid, 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        push(55'd4, 16'd1, 1'b0);
        send(55'd2, 24'd2, 1'b0, 1'b1);
        drain();

        // Reset during a stall: pending result is dropped
        out_ready = 1'b0;
        send(55'd7, 24'd7, 1'b1, 1'b1);
        wait_out();
        #1;
        ap_rst_n = 1'b0;
        #1;
        check("stall_rst_out_valid", out_valid, 0);
        check("stall_rst_out_data", out_data, 0);
        check("stall_rst_in_ready", in_ready, 1);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        out_ready = 1'b1;
        push(55'd5, 16'd1, 1'b0);
        send(55'd1, 24'd5, 1'b1, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
